// File: rtl/fpga_cfg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpga_cfg_pkg: shared state encoding and defaults for cfg loading.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fpga_cfg_pkg;

  localparam int CFG_BITS_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_stream_if: minimal AXI-stream bundle (tvalid/tready/tdata/tlast)|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface axi_stream_if #(
  parameter int DATA_WIDTH = 1
) ();

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/fpga_cfg_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpga_cfg_loader: deserialises a 1-bit config stream into a shadow  |
// | register and commits it to cfg_word on a correctly framed load.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_BITS             = CFG_BITS_DEFAULT,
  parameter int BITSTREAM_DATA_WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg,
  axi_stream_if.slave         cfg_bitstream,
  output logic                cfg_ready,
  output logic                cfg_err,
  output logic [CFG_BITS-1:0] cfg_word
);

  localparam int              CNT_W    = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

  generate
    if (BITSTREAM_DATA_WIDTH != 1) begin : g_bad_width
      $error("fpga_cfg_loader: only BITSTREAM_DATA_WIDTH == 1 is supported");
    end
    if (CFG_BITS < 2) begin : g_bad_bits
      $error("fpga_cfg_loader: CFG_BITS must be at least 2");
    end
  endgenerate

  cfg_state_e          state_q, state_d;
  logic                cfg_q, cfg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] cfg_word_q, cfg_word_d;

  logic tready;
  logic cfg_rise;
  logic beat;

  // tready comes from the registered state only, so it never depends on tvalid.
  assign tready   = (state_q == LOAD);
  assign cfg_rise = cfg & ~cfg_q;
  assign beat     = cfg_bitstream.tvalid & tready;

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    cfg_word_d = cfg_word_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (cfg_rise) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        // A beat outranks a cfg drop in the same cycle; the abort waits a cycle.
        if (beat) begin
          shadow_d = {cfg_bitstream.tdata[0], shadow_q[CFG_BITS-1:1]};
          cnt_d    = cnt_q + 1'b1;
          if (cfg_bitstream.tlast) begin
            if (cnt_q == CNT_LAST) begin
              state_d    = DONE;
              cfg_word_d = shadow_d;
            end else begin
              state_d = ERROR;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_d = ERROR;
          end
        end else if (!cfg) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cfg_q      <= 1'b0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      cfg_word_q <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      cfg_word_q <= cfg_word_d;
    end
  end

  assign cfg_bitstream.tready = tready;
  assign cfg_ready            = (state_q == DONE);
  assign cfg_err              = (state_q == ERROR);
  assign cfg_word             = cfg_word_q;

endmodule
`default_nettype wire
